// File: rtl/cadence_pkg.sv
// Shared constants for the crank cadence front end: output width, default
// window/debounce lengths and their fast-simulation counterparts.
package cadence_pkg;

    localparam int                CAD_W   = 5;
    localparam logic [CAD_W-1:0]  CAD_MAX = 5'd31;

    localparam int WINDOW_CYCLES_DEF      = 16777216;
    localparam int DEBOUNCE_CYCLES_DEF    = 1024;
    localparam int FAST_WINDOW_CYCLES     = 4096;
    localparam int FAST_DEBOUNCE_CYCLES   = 4;
    localparam int NP_THRESH_DEF          = 2;

    // Increment that sticks at CAD_MAX instead of wrapping.
    function automatic logic [CAD_W-1:0] sat_inc(input logic [CAD_W-1:0] cnt,
                                                 input logic             inc);
        if (inc && (cnt != CAD_MAX)) begin
            return cnt + CAD_W'(1);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cadence_debounce.sv
// Two-flop synchronizer plus run-length debounce filter for the crank sensor;
// emits the filtered level and a one-cycle pulse on its rising edge.
module cadence_debounce #(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cadence_raw,
    output logic filt,
    output logic rise
);

    localparam int               DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_TC = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic             filt_d;
    logic             filt_dly_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;

    // The filtered level only moves after DEBOUNCE_CYCLES consecutive disagreements.
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (deb_cnt_q == DEB_TC) begin
                filt_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            deb_cnt_q  <= '0;
        end else begin
            sync1_q    <= cadence_raw;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    assign filt = filt_q;
    assign rise = filt_q & ~filt_dly_q;

endmodule

// File: rtl/cadence_meas.sv
// Crank cadence measurement: counts debounced rising edges per fixed window and
// publishes a saturated count plus not-pedaling flag. Macro CADENCE_FAST_SIM_EN
// shrinks window/debounce to 4096/4 cycles for simulation.
module cadence_meas
    import cadence_pkg::*;
#(
    parameter int WINDOW_CYCLES   = WINDOW_CYCLES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int NP_THRESH       = NP_THRESH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cadence_raw,
    output logic [CAD_W-1:0] cadence,
    output logic             not_pedaling,
    output logic             cadence_vld
);

`ifdef CADENCE_FAST_SIM_EN
    localparam int EFF_WIN = FAST_WINDOW_CYCLES;
    localparam int EFF_DEB = FAST_DEBOUNCE_CYCLES;
`else
    localparam int EFF_WIN = WINDOW_CYCLES;
    localparam int EFF_DEB = DEBOUNCE_CYCLES;
`endif

    localparam int               WIN_W  = $clog2(EFF_WIN);
    localparam logic [WIN_W-1:0] WIN_TC = WIN_W'(EFF_WIN - 1);

    if (WINDOW_CYCLES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("cadence_meas: window must be >= 2 and debounce >= 1 cycles");
    end

    logic             rise;
    logic             filt_unused;
    logic [WIN_W-1:0] win_cnt_q;
    logic [CAD_W-1:0] edge_cnt_q;
    logic [CAD_W-1:0] edge_cnt_d;
    logic [CAD_W-1:0] cadence_q;
    logic             not_pedaling_q;
    logic             cadence_vld_q;
    logic             win_close;

    cadence_debounce #(
        .DEBOUNCE_CYCLES(EFF_DEB)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .cadence_raw (cadence_raw),
        .filt        (filt_unused),
        .rise        (rise)
    );

    // A rise landing on the closing cycle is folded into the closing window.
    always_comb begin
        win_close  = (win_cnt_q == WIN_TC);
        edge_cnt_d = sat_inc(edge_cnt_q, rise);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt_q      <= '0;
            edge_cnt_q     <= '0;
            cadence_q      <= '0;
            not_pedaling_q <= 1'b1;
            cadence_vld_q  <= 1'b0;
        end else begin
            cadence_vld_q <= win_close;
            if (win_close) begin
                win_cnt_q      <= '0;
                edge_cnt_q     <= '0;
                cadence_q      <= edge_cnt_d;
                not_pedaling_q <= (int'(edge_cnt_d) < NP_THRESH);
            end else begin
                win_cnt_q  <= win_cnt_q + WIN_W'(1);
                edge_cnt_q <= edge_cnt_d;
            end
        end
    end

    assign cadence      = cadence_q;
    assign not_pedaling = not_pedaling_q;
    assign cadence_vld  = cadence_vld_q;

endmodule

// File: tb/tb_cadence_meas.sv
// Self-checking bench for cadence_meas using a 4096-cycle window and 4-cycle
// debounce; a history-based reference model predicts every output cycle.
module tb_cadence_meas;
    import cadence_pkg::*;

    localparam int W   = 4096;
    localparam int DEB = 4;
    localparam int NPT = 2;

    localparam int K_SQ256  = 0;
    localparam int K_SQ64   = 1;
    localparam int K_GLITCH = 2;
    localparam int K_ONE    = 3;
    localparam int K_TWO    = 4;
    localparam int K_LOW    = 5;
    localparam int K_RAND   = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cadence_raw = 1'b0;
    logic [CAD_W-1:0] cadence;
    logic             not_pedaling;
    logic             cadence_vld;

    always #5 clk = ~clk;

    cadence_meas #(
        .WINDOW_CYCLES   (W),
        .DEBOUNCE_CYCLES (DEB),
        .NP_THRESH       (NPT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cadence_raw  (cadence_raw),
        .cadence      (cadence),
        .not_pedaling (not_pedaling),
        .cadence_vld  (cadence_vld)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw samples reach the filter two cycles late; the
    // filtered level flips once the last DEB synchronized samples all disagree
    // with it, and the resulting rising edge is counted one cycle later.
    bit rq[$];
    bit yh[$];
    bit mf, pend;
    int n_edge;
    int wedges;
    int exp_cad;
    bit exp_np, exp_vld;

    task automatic model_step(input bit r, input bit rn);
        bit y, rise_now, all_diff;
        if (!rn) begin
            n_edge  = 0;
            rq      = '{1'b0, 1'b0};
            yh.delete();
            mf      = 1'b0;
            pend    = 1'b0;
            wedges  = 0;
            exp_cad = 0;
            exp_np  = 1'b1;
            exp_vld = 1'b0;
            return;
        end
        rq.push_back(r);
        y        = rq.pop_front();
        rise_now = pend;
        pend     = 1'b0;
        yh.push_back(y);
        if (yh.size() > DEB) void'(yh.pop_front());
        if (yh.size() == DEB) begin
            all_diff = 1'b1;
            foreach (yh[i]) if (yh[i] == mf) all_diff = 1'b0;
            if (all_diff) begin
                mf   = ~mf;
                pend = mf;
            end
        end
        n_edge++;
        if (rise_now) wedges++;
        if (n_edge % W == 0) begin
            exp_cad = (wedges > 31) ? 31 : wedges;
            exp_np  = (exp_cad < NPT);
            exp_vld = 1'b1;
            wedges  = 0;
        end else begin
            exp_vld = 1'b0;
        end
    endtask

    task automatic tick(input bit r, input bit rn);
        @(negedge clk);
        cadence_raw = r;
        rst_n       = rn;
        @(posedge clk);
        model_step(r, rn);
        #1;
        chk("vld", cadence_vld, exp_vld);
        chk("cadence", cadence, exp_cad);
        chk("not_pedaling", not_pedaling, exp_np);
    endtask

    function automatic bit stim(input int kind, input int i);
        case (kind)
            K_SQ256:  return (i % 256) < 128;
            K_SQ64:   return (i % 64) < 32;
            K_GLITCH: return (i % 100) < 3;
            K_ONE:    return i >= 1000;
            K_TWO:    return ((i >= 500) && (i < 1000)) || (i >= 1500);
            default:  return 1'b0;
        endcase
    endfunction

    bit rnd_lvl = 1'b0;
    int rnd_left = 0;

    task automatic run_phase(input int kind, input int cycles, output int first_vld);
        bit r;
        first_vld = -1;
        for (int i = 0; i < cycles; i++) begin
            if (kind == K_RAND) begin
                if (rnd_left == 0) begin
                    rnd_lvl  = ~rnd_lvl;
                    rnd_left = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 8)
                                                          : $urandom_range(9, 300);
                end
                rnd_left--;
                r = rnd_lvl;
            end else begin
                r = stim(kind, i);
            end
            tick(r, 1'b1);
            if (cadence_vld && first_vld < 0) first_vld = i + 1;
        end
    endtask

    int fv;

    initial begin
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        chk("rst_cadence", cadence, 0);
        chk("rst_not_pedaling", not_pedaling, 1);
        chk("rst_vld", cadence_vld, 0);

        run_phase(K_SQ256, 3 * W, fv);
        chk("first_vld_latency", fv, W);
        chk("sq256_cadence", cadence, 16);
        chk("sq256_not_pedaling", not_pedaling, 0);

        run_phase(K_SQ64, 2 * W, fv);
        chk("sq64_cadence_sat", cadence, 31);
        chk("sq64_not_pedaling", not_pedaling, 0);

        run_phase(K_GLITCH, 2 * W, fv);
        chk("glitch_cadence", cadence, 0);
        chk("glitch_not_pedaling", not_pedaling, 1);

        run_phase(K_ONE, W, fv);
        chk("one_edge_cadence", cadence, 1);
        chk("one_edge_not_pedaling", not_pedaling, 1);

        run_phase(K_TWO, W, fv);
        chk("two_edge_cadence", cadence, 2);
        chk("two_edge_not_pedaling", not_pedaling, 0);

        run_phase(K_LOW, W, fv);
        chk("low_cadence", cadence, 0);
        chk("low_not_pedaling", not_pedaling, 1);

        run_phase(K_SQ256, W, fv);
        chk("pre_reset_cadence", cadence, 16);
        run_phase(K_SQ256, 2000, fv);
        tick(1'b1, 1'b0);
        chk("midrst_cadence", cadence, 0);
        chk("midrst_not_pedaling", not_pedaling, 1);
        chk("midrst_vld", cadence_vld, 0);
        run_phase(K_SQ256, W, fv);
        chk("post_reset_first_vld", fv, W);
        chk("post_reset_cadence", cadence, 16);

        run_phase(K_RAND, 3 * W, fv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cadence_meas.md
Name: cadence_meas

Overview:
- Front end that produces the `cadence` and `not_pedaling` inputs consumed by the desired-drive math.
- Takes the raw, asynchronous crank cadence sensor pin, synchronizes and debounces it, and counts rising edges over a fixed measurement window.
- Publishes a saturated 5-bit cadence plus a not-pedaling flag once per window.

Parameters:
- WINDOW_CYCLES, 16777216 (2^24, ≈0.335 s at 50 MHz): length of the measurement window in clk cycles.
- DEBOUNCE_CYCLES, 1024: number of consecutive cycles the synchronized input must differ from the filtered level before the filtered level flips.
- NP_THRESH, 2: not_pedaling asserts when the latched cadence is below this value.

Ports:
- clk  input  1  50 MHz system clock.
- rst_n  input  1  reset, synchronous active-low.
- cadence_raw  input  1  raw crank sensor level, asynchronous to clk.
- cadence  output  5  rising edges counted in the last completed window, saturated at 31.
- not_pedaling  output  1  high when cadence < NP_THRESH.
- cadence_vld  output  1  one-cycle pulse when cadence/not_pedaling update.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n, sampled on posedge clk).
- Reset values: cadence=0, not_pedaling=1, cadence_vld=0. Sync flops, filtered level, debounce counter, window counter and edge counter all clear to 0.
- Synchronizer: two flops on cadence_raw.
- Debounce:
  - deb_cnt clears whenever the synchronized level equals the filtered level.
  - Otherwise deb_cnt increments.
  - When deb_cnt == DEBOUNCE_CYCLES-1 while still differing, the filtered level takes the synchronized value and deb_cnt clears.
  - Any shorter excursion is discarded.
- Edge detect: rise = filt & ~filt_q.
  - Latency from a clean cadence_raw rising edge to rise is 2 + DEBOUNCE_CYCLES + 1 cycles (deterministic, ±1 for the async sample).
- Window counter:
  - Free-runs 0..WINDOW_CYCLES-1 and wraps to 0.
  - The terminal count (WINDOW_CYCLES-1) is the window close.
- Edge counter (5 bits): increments on rise and holds at 31 (no wrap).
- At window close:
  - cadence <= sat31(edge_cnt + rise); a rise on the closing cycle belongs to the closing window.
  - not_pedaling <= (that new value < NP_THRESH).
  - cadence_vld = 1 for exactly that cycle.
  - edge_cnt <= 0.
- Outputs are registered and hold between window closes.
- First update occurs WINDOW_CYCLES cycles after reset release.
- No edges in a window gives cadence=0, not_pedaling=1.
- Reset asserted mid-window: on the next posedge all state returns to its reset value. The partial window is discarded and counting restarts at 0 when rst_n rises.
- A level held constant forever produces no edges (stuck-high sensor reads as not pedaling).

Optional Feature:
- Macro CADENCE_FAST_SIM_EN.
- When defined: effective window = 4096 cycles and effective debounce = 4 cycles (overriding the parameters), for simulation runtime.
- When undefined: WINDOW_CYCLES and DEBOUNCE_CYCLES are used as given.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package cadence_pkg holds:
  - CAD_W=5 and CAD_MAX=5'd31.
  - Default window and debounce constants, plus their fast-sim counterparts.
  - NP_THRESH default.
- One natural sub-module, cadence_debounce: synchronizer, debounce counter and filtered level, with outputs filt and rise.
- The top level holds the window counter, edge counter and output registers.

Test Plan (CADENCE_FAST_SIM_EN defined):
- Reset held 5 cycles → cadence=0, not_pedaling=1, cadence_vld=0; first cadence_vld exactly 4096 cycles after rst_n rises.
- Square wave, period 256 (128 high/128 low), steady state → every window cadence=16, not_pedaling=0, cadence_vld pulses every 4096 cycles.
- Square wave, period 64 → cadence=31 (saturated, edge_cnt not wrapped), not_pedaling=0.
- 3-cycle-wide high glitches every 100 cycles → filtered out; cadence=0, not_pedaling=1.
- Exactly 1 clean edge in a window → cadence=1, not_pedaling=1. Exactly 2 edges → cadence=2, not_pedaling=0. Then input held low a full window → cadence=0, not_pedaling=1.
- Period-256 stimulus with rst_n pulsed low for 1 cycle at window count 2000 → next cycle outputs at reset values. No vld at old window close; next vld 4096 cycles after rst_n rises.
